fixed_point_iterative_mac: RTL and testbench
============================================

// Module: fixed_point_iterative_mac
// PURPOSE
//  Parametrised iterative signed fixed-point multiply/accumulate unit; next generation of the
//  team's iterative fixed-point multiplier. Adds radix-2^k iteration, an internal accumulator
//  with MUL/MAC/CLR ops, and optional saturation. Sits behind val/rdy streams in the FFT and
//  filter datapaths.
// PARAMETERS
//  n  32  total word width (two's complement Q(n-d).d)
//  d  16  fractional bits; 0 <= d < n
//  k  1   multiplier bits consumed per cycle; k >= 1 and n % k == 0
// PORTS
//  clk       in   1  clock
//  reset     in   1  asynchronous, active-high reset
//  recv_val  in   1  request valid
//  recv_rdy  out  1  request ready
//  a         in   n  multiplicand (signed, Q(n-d).d)
//  b         in   n  multiplier (signed, Q(n-d).d)
//  op        in   2  0=MUL, 1=MAC, 2=CLR, 3=reserved (treated as MUL)
//  send_val  out  1  result valid
//  send_rdy  in   1  result ready
//  c         out  n  result
// BEHAVIOUR
//  - Reset, async: state=IDLE, acc=0, c=0, send_val=0; recv_rdy=1 from the first clock after release.
//  - FSM: IDLE -> CALC on recv_val&&recv_rdy with op!=CLR; IDLE -> DONE on an accepted CLR.
//    CALC runs n/k cycles (counter 0..n/k-1), then DONE. DONE -> IDLE on send_rdy.
//  - recv_rdy=1 only in IDLE; send_val=1 only in DONE. No request is accepted in the cycle a result
//    is consumed: one transaction in flight.
//  - Latency: a MUL/MAC accepted at edge t shows send_val at edge t+n/k+1. A CLR shows it at edge t+1.
//  - Operands and op are registered at accept; later input changes are ignored.
//  - Product: exact 2n-bit signed a*b, arithmetic shift right by d (floor). Result is bits [n-1:0]
//    of the shifted value.
//  - MUL: c = product; acc unchanged.
//  - MAC: acc = acc + product (n-bit add); c = new acc.
//  - CLR: acc = 0; c = 0.
//  - c and acc update only on the CALC->DONE (or CLR) transition. c holds stable while
//    send_val && !send_rdy.
//  - Reset mid-CALC or mid-DONE aborts the operation: no result is issued and acc returns to 0.
//  - Boundary cases: b=0 or a=0 gives exact 0. The most negative value (-2^(n-1)) is legal in
//    either operand and needs no special case.
// CONFIGURATION
//  FIXED_POINT_ITERATIVE_MAC_SAT_EN
//   defined: the MUL result and the MAC sum are each clamped to [-2^(n-1), 2^(n-1)-1] when the
//            shifted product (or the (n+1)-bit sum) is out of range.
//   undefined: both wrap modulo 2^n.
// STRUCTURE
//  - Shared package fixed_point_pkg holds:
//      - typedef enum fxp_op_t {FXP_MUL, FXP_MAC, FXP_CLR};
//      - typedef enum fxp_mac_state_t {IDLE, CALC, DONE};
//      - a function computing the iteration count n/k.
//  - One sub-module, fixed_point_sat #(n, w): combinational clamp of a w-bit signed value to
//    n bits. It is instantiated twice (product, accumulator) and only under the macro.
//  - The iterative shift-add datapath and the FSM live in this module.
// TESTING (n=32, d=16, k=1 unless noted)
//  1. MUL a=0x00018000 b=0x00020000 -> c=0x00030000; send_val at handshake+33 edges;
//     recv_rdy=0 throughout CALC.
//  2. MUL a=0xFFFFFFFF b=0x00008000 -> c=0xFFFFFFFF (floor rounding). Also a=0xFFFE8000,
//     b=0x00020000 -> c=0xFFFD0000.
//  3. CLR; MAC 0x00010000*0x00008000 -> c=0x00008000; MAC 0x00010000*0x00004000 ->
//     c=0x0000C000; MUL in between leaves acc untouched.
//  4. MUL 0x7FFF0000*0x00020000 -> c=0xFFFE0000 (macro off) / 0x7FFFFFFF (macro on). The
//     negative case 0x80000000*0x00020000 -> 0x00000000 / 0x80000000.
//  5. Hold send_rdy=0 for 5 cycles in DONE: c and send_val stable, recv_rdy=0. Then assert reset
//     mid-CALC at cycle 10: send_val never rises, and the next MAC starts from acc=0.
//  6. k=4 and k=8 rerun scenarios 1-4: identical results, latency n/k+1 (9 and 5 edges).

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point iterative MAC family.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        FXP_MUL = 2'd0,
        FXP_MAC = 2'd1,
        FXP_CLR = 2'd2
    } fxp_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fxp_mac_state_t;

    // Number of shift-add iterations for a width consumed radix_bits at a time.
    function automatic int iter_count(input int width, input int radix_bits);
        return width / radix_bits;
    endfunction

endpackage

// File: rtl/fixed_point_sat.sv
// Combinational clamp of a w-bit signed value into the n-bit two's complement range.
module fixed_point_sat #(
    parameter int n = 32,
    parameter int w = 64
) (
    input  logic signed [w-1:0] din,
    output logic        [n-1:0] dout
);

    localparam int HW = w - n + 1;

    logic [HW-1:0] head;

    // In range exactly when every bit from the n-bit sign position upward agrees.
    assign head = din[w-1:n-1];

    always_comb begin
        if (head == '0 || head == '1) begin
            dout = din[n-1:0];
        end else if (din[w-1]) begin
            dout = {1'b1, {(n-1){1'b0}}};
        end else begin
            dout = {1'b0, {(n-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fixed_point_iterative_mac.sv
// Iterative radix-2^k signed fixed-point multiply/accumulate with val/rdy streams.
// Optional saturation of product and accumulator: define FIXED_POINT_ITERATIVE_MAC_SAT_EN.
module fixed_point_iterative_mac
    import fixed_point_pkg::*;
#(
    parameter int n = 32,
    parameter int d = 16,
    parameter int k = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         recv_val,
    output logic         recv_rdy,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [1:0]   op,
    output logic         send_val,
    input  logic         send_rdy,
    output logic [n-1:0] c
);

    localparam int ITER = iter_count(n, k);
    localparam int CW   = $clog2(ITER) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    fxp_mac_state_t state_reg, state_next;
    fxp_op_t        op_reg;

    logic signed [2*n-1:0] mcand_reg;
    logic signed [2*n-1:0] prod_reg;
    logic        [n-1:0]   mplier_reg;
    logic        [CW-1:0]  cnt_reg;
    logic        [n-1:0]   acc_reg;
    logic        [n-1:0]   c_reg;

    logic                  last_iter;
    logic        [k-1:0]   digit;
    logic signed [k:0]     digit_ext;
    logic signed [2*n-1:0] digit_wide;
    logic signed [2*n-1:0] partial;
    logic signed [2*n-1:0] prod_sum;
    logic        [n-1:0]   prod_n;
    logic        [n-1:0]   mac_n;

    // The top digit of b carries the sign weight, so it is taken as signed; the rest are unsigned.
    assign last_iter  = (cnt_reg == LAST_CNT);
    assign digit      = mplier_reg[k-1:0];
    assign digit_ext  = last_iter ? {digit[k-1], digit} : {1'b0, digit};
    assign digit_wide = (2*n)'(digit_ext);
    assign partial    = mcand_reg * digit_wide;
    assign prod_sum   = prod_reg + partial;

`ifdef FIXED_POINT_ITERATIVE_MAC_SAT_EN
    logic signed [2*n-1:0] prod_shifted;
    logic signed [n:0]     mac_wide;

    assign prod_shifted = prod_sum >>> d;
    assign mac_wide     = {acc_reg[n-1], acc_reg} + {prod_n[n-1], prod_n};

    fixed_point_sat #(.n(n), .w(2*n)) u_sat_prod (
        .din  (prod_shifted),
        .dout (prod_n)
    );

    fixed_point_sat #(.n(n), .w(n+1)) u_sat_acc (
        .din  (mac_wide),
        .dout (mac_n)
    );
`else
    // Floor shift then truncate is just a bit-select of the exact product.
    assign prod_n = prod_sum[n+d-1:d];
    assign mac_n  = acc_reg + prod_n;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        recv_rdy   = 1'b0;
        send_val   = 1'b0;
        case (state_reg)
            IDLE: begin
                recv_rdy = 1'b1;
                if (recv_val) begin
                    state_next = (op == FXP_CLR) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                send_val = 1'b1;
                if (send_rdy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg     <= FXP_MUL;
            mcand_reg  <= '0;
            prod_reg   <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            c_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (recv_val) begin
                        mcand_reg  <= {{n{a[n-1]}}, a};
                        mplier_reg <= b;
                        prod_reg   <= '0;
                        cnt_reg    <= '0;
                        if (op == FXP_MAC) begin
                            op_reg <= FXP_MAC;
                        end else if (op == FXP_CLR) begin
                            op_reg <= FXP_CLR;
                        end else begin
                            op_reg <= FXP_MUL;
                        end
                        if (op == FXP_CLR) begin
                            acc_reg <= '0;
                            c_reg   <= '0;
                        end
                    end
                end
                CALC: begin
                    prod_reg   <= prod_sum;
                    mcand_reg  <= mcand_reg << k;
                    mplier_reg <= mplier_reg >> k;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (last_iter) begin
                        if (op_reg == FXP_MAC) begin
                            acc_reg <= mac_n;
                            c_reg   <= mac_n;
                        end else begin
                            c_reg   <= prod_n;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign c = c_reg;

endmodule

// File: tb/tb_fixed_point_iterative_mac.sv
// Bench for fixed_point_iterative_mac: k=1, 4 and 8 instances against a plain-arithmetic model.
module tb_fixed_point_iterative_mac;

    localparam int NDUT = 3;
    localparam longint MAXV = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MINV = 64'shFFFF_FFFF_8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        recv_val [NDUT];
    logic        recv_rdy [NDUT];
    logic [31:0] a        [NDUT];
    logic [31:0] b        [NDUT];
    logic [1:0]  op       [NDUT];
    logic        send_val [NDUT];
    logic        send_rdy [NDUT];
    logic [31:0] c        [NDUT];

    logic [31:0] acc_m [NDUT];
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    function automatic int kval(input int i);
        return (i == 0) ? 1 : (i == 1) ? 4 : 8;
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        fixed_point_iterative_mac #(.n(32), .d(16), .k(kval(gi))) u_dut (
            .clk      (clk),
            .reset    (reset),
            .recv_val (recv_val[gi]),
            .recv_rdy (recv_rdy[gi]),
            .a        (a[gi]),
            .b        (b[gi]),
            .op       (op[gi]),
            .send_val (send_val[gi]),
            .send_rdy (send_rdy[gi]),
            .c        (c[gi])
        );
    end

    function automatic logic [31:0] clamp32(input longint v);
        longint t;
        t = v;
`ifdef FIXED_POINT_ITERATIVE_MAC_SAT_EN
        if (v > MAXV) t = MAXV;
        else if (v < MINV) t = MINV;
`endif
        return t[31:0];
    endfunction

    // Reference: exact product, floor-divide by 2^16, then wrap or clamp to 32 bits.
    function automatic logic [31:0] model_step(input int idx, input logic [1:0] opv,
                                               input logic [31:0] av, input logic [31:0] bv);
        longint p;
        logic [31:0] pn;
        if (opv == 2'd2) begin
            acc_m[idx] = 32'h0;
            return 32'h0;
        end
        p  = longint'($signed(av)) * longint'($signed(bv));
        p  = p >>> 16;
        pn = clamp32(p);
        if (opv == 2'd1) begin
            acc_m[idx] = clamp32(longint'($signed(acc_m[idx])) + longint'($signed(pn)));
            return acc_m[idx];
        end
        return pn;
    endfunction

    task automatic issue(input int idx, input logic [31:0] av, input logic [31:0] bv,
                         input logic [1:0] opv);
        @(negedge clk);
        for (int w = 0; w < 200 && !recv_rdy[idx]; w++) @(negedge clk);
        a[idx] = av;
        b[idx] = bv;
        op[idx] = opv;
        recv_val[idx] = 1'b1;
        @(posedge clk);
        #1;
        recv_val[idx] = 1'b0;
        a[idx] = $urandom;
        b[idx] = $urandom;
        op[idx] = 2'($urandom_range(0, 3));
    endtask

    // lat counts edges after the handshake edge until send_val is seen (valid at edge t+lat+1).
    task automatic wait_result(input int idx, output int lat, output bit rdy_low);
        lat = 0;
        rdy_low = 1'b1;
        while (!send_val[idx] && lat < 200) begin
            if (recv_rdy[idx]) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!send_val[idx]) lat = -1;
        if (recv_rdy[idx]) rdy_low = 1'b0;
    endtask

    task automatic consume(input int idx);
        @(negedge clk);
        send_rdy[idx] = 1'b1;
        @(posedge clk);
        #1;
        send_rdy[idx] = 1'b0;
    endtask

    task automatic do_op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                         input logic [1:0] opv, output logic [31:0] cv, output int lat,
                         output bit rdy_low);
        issue(idx, av, bv, opv);
        wait_result(idx, lat, rdy_low);
        cv = c[idx];
        $display("[TB] dut%0d k=%0d op=%0d a=%08h b=%08h c=%08h lat=%0d",
                 idx, kval(idx), opv, av, bv, cv, lat);
        consume(idx);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) acc_m[i] = 32'h0;
        #2;
        for (int i = 0; i < NDUT; i++) begin
            tests_run++;
            if (send_val[i] !== 1'b0 || c[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL async_reset dut%0d: send_val=%b c=%08h, want 0 and 00000000",
                         i, send_val[i], c[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            tests_run++;
            if (recv_rdy[i] !== 1'b1 || send_val[i] !== 1'b0 || c[i] !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_state dut%0d: rdy=%b val=%b c=%08h, want 1 0 00000000",
                         i, recv_rdy[i], send_val[i], c[i]);
            end
        end
    endtask

    // Directed vectors for MUL/MAC/CLR, including floor rounding and wrap/saturation edges.
    task automatic test_directed(input int idx);
        logic [31:0] vec_a [10] = '{32'h0, 32'h00018000, 32'hFFFFFFFF, 32'hFFFE8000,
                                    32'h00010000, 32'h00050000, 32'h00010000,
                                    32'h7FFF0000, 32'h80000000, 32'h80000000};
        logic [31:0] vec_b [10] = '{32'h0, 32'h00020000, 32'h00008000, 32'h00020000,
                                    32'h00008000, 32'h00030000, 32'h00004000,
                                    32'h00020000, 32'h00020000, 32'h0};
        logic [1:0]  vec_op[10] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0};
        logic [31:0] cv, exp_c;
        int lat, exp_lat;
        bit rdy_low;
        for (int v = 0; v < 10; v++) begin
            exp_c = model_step(idx, vec_op[v], vec_a[v], vec_b[v]);
            exp_lat = (vec_op[v] == 2'd2) ? 0 : 32 / kval(idx);
            do_op(idx, vec_a[v], vec_b[v], vec_op[v], cv, lat, rdy_low);
            tests_run++;
            if (cv !== exp_c) begin
                tests_failed++;
                $display("FAIL directed_c dut%0d v%0d: got %08h want %08h", idx, v, cv, exp_c);
            end
            tests_run++;
            if (lat != exp_lat || !rdy_low) begin
                tests_failed++;
                $display("FAIL directed_lat dut%0d v%0d: lat=%0d rdy_low=%0b want lat=%0d rdy_low=1",
                         idx, v, lat, rdy_low, exp_lat);
            end
        end
    endtask

    task automatic test_random(input int idx, input int count);
        logic [31:0] av, bv, cv, exp_c;
        logic [1:0] opv;
        int lat;
        bit rdy_low;
        for (int t = 0; t < count; t++) begin
            case ($urandom_range(0, 5))
                0: av = 32'h80000000;
                1: av = 32'h0;
                default: av = $urandom;
            endcase
            bv = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            opv = 2'($urandom_range(0, 3));
            exp_c = model_step(idx, opv, av, bv);
            do_op(idx, av, bv, opv, cv, lat, rdy_low);
            tests_run++;
            if (cv !== exp_c) begin
                tests_failed++;
                $display("FAIL random_c dut%0d op=%0d a=%08h b=%08h: got %08h want %08h",
                         idx, opv, av, bv, cv, exp_c);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_c, cv;
        int lat;
        bit rdy_low;
        exp_c = model_step(0, 2'd0, 32'h00030000, 32'hFFFF8000);
        issue(0, 32'h00030000, 32'hFFFF8000, 2'd0);
        wait_result(0, lat, rdy_low);
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (send_val[0] !== 1'b1 || recv_rdy[0] !== 1'b0 || c[0] !== exp_c) begin
                tests_failed++;
                $display("FAIL hold cyc%0d: val=%b rdy=%b c=%08h, want 1 0 %08h",
                         cyc, send_val[0], recv_rdy[0], c[0], exp_c);
            end
        end
        consume(0);
        $display("[TB] dut0 held result c=%08h for 5 cycles", exp_c);
        tests_run++;
        if (send_val[0] !== 1'b0 || recv_rdy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL consume: val=%b rdy=%b, want 0 1", send_val[0], recv_rdy[0]);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] cv, exp_c;
        int lat, rises;
        bit rdy_low;
        exp_c = model_step(0, 2'd1, 32'h00010000, 32'h00010000);
        do_op(0, 32'h00010000, 32'h00010000, 2'd1, cv, lat, rdy_low);
        issue(0, 32'h00020000, 32'h00020000, 2'd1);
        repeat (10) @(posedge clk);
        apply_reset();
        rises = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (send_val[0]) rises++;
        end
        tests_run++;
        if (rises != 0) begin
            tests_failed++;
            $display("FAIL abort_no_result: send_val high %0d cycles, want 0", rises);
        end
        exp_c = model_step(0, 2'd1, 32'h00010000, 32'h00008000);
        do_op(0, 32'h00010000, 32'h00008000, 2'd1, cv, lat, rdy_low);
        tests_run++;
        if (cv !== exp_c) begin
            tests_failed++;
            $display("FAIL abort_acc_cleared: got %08h want %08h", cv, exp_c);
        end
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            recv_val[i] = 1'b0;
            send_rdy[i] = 1'b0;
            a[i] = 32'h0;
            b[i] = 32'h0;
            op[i] = 2'd0;
            acc_m[i] = 32'h0;
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        test_reset();
        for (int i = 0; i < NDUT; i++) test_directed(i);
        for (int i = 0; i < NDUT; i++) test_random(i, 30);
        test_backpressure();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
